// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator: digit-serial magnitude comparator of operand P against a
// stored reference Q, MSB digit first, with active-low device-style results.
// Optional build macro: SEQ_CMP_EARLY_EXIT_EN (stop the scan at the first
// unequal digit instead of always scanning all NDIG digits).
module seq_mag_comparator #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGIT  = 4,
  parameter int unsigned SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_load,
  input  logic [WIDTH-1:0] q_in,
  input  logic             start,
  input  logic [WIDTH-1:0] p_in,
  output logic             busy,
  output logic             done,
  output logic             p_eq_q_n,
  output logic             p_gt_q_n,
  output logic             p_lt_q_n
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NDIG - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       r_state, w_state;
  logic [WIDTH-1:0] r_q, w_q;
  logic [WIDTH-1:0] r_p, w_p;
  logic [IDXW-1:0]  r_idx, w_idx;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_eq_n, w_eq_n;
  logic             r_gt_n, w_gt_n;
  logic             r_lt_n, w_lt_n;
  logic             r_dec_gt, w_dec_gt_nx;
  logic             r_dec_lt, w_dec_lt_nx;

  logic [DIGIT-1:0] w_p_dig;
  logic [DIGIT-1:0] w_q_dig;
  logic             w_dig_gt;
  logic             w_dig_lt;
  logic             w_res_gt;
  logic             w_res_lt;
  logic             w_finish;

  // Select the current digit of P and Q; signed mode biases the top digit
  always_comb begin
    w_p_dig = '0;
    w_q_dig = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (r_idx == IDXW'(i)) begin
        w_p_dig = r_p[i*DIGIT +: DIGIT];
        w_q_dig = r_q[i*DIGIT +: DIGIT];
      end
    end
    if ((SIGNED != 0) && (r_idx == IDX_TOP)) begin
      w_p_dig[DIGIT-1] = ~w_p_dig[DIGIT-1];
      w_q_dig[DIGIT-1] = ~w_q_dig[DIGIT-1];
    end
  end

  // Digit compare merged with any decision already latched from a higher digit
  always_comb begin
    w_dig_gt = (w_p_dig > w_q_dig);
    w_dig_lt = (w_p_dig < w_q_dig);
    w_res_gt = r_dec_gt | (~r_dec_gt & ~r_dec_lt & w_dig_gt);
    w_res_lt = r_dec_lt | (~r_dec_gt & ~r_dec_lt & w_dig_lt);
`ifdef SEQ_CMP_EARLY_EXIT_EN
    w_finish = (r_idx == '0) | w_dig_gt | w_dig_lt;
`else
    w_finish = (r_idx == '0);
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    w_state     = r_state;
    w_q         = r_q;
    w_p         = r_p;
    w_idx       = r_idx;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_eq_n      = r_eq_n;
    w_gt_n      = r_gt_n;
    w_lt_n      = r_lt_n;
    w_dec_gt_nx = r_dec_gt;
    w_dec_lt_nx = r_dec_lt;
    case (r_state)
      S_IDLE: begin
        if (q_load) begin
          w_q = q_in;
        end
        if (start) begin
          w_p         = p_in;
          w_idx       = IDX_TOP;
          w_busy      = 1'b1;
          w_dec_gt_nx = 1'b0;
          w_dec_lt_nx = 1'b0;
          w_state     = S_RUN;
        end
      end
      S_RUN: begin
        w_dec_gt_nx = w_res_gt;
        w_dec_lt_nx = w_res_lt;
        if (w_finish) begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_idx   = IDX_TOP;
          w_gt_n  = ~w_res_gt;
          w_lt_n  = ~w_res_lt;
          w_eq_n  = w_res_gt | w_res_lt;
        end else begin
          w_idx = r_idx - 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_q      <= '0;
      r_p      <= '0;
      r_idx    <= IDX_TOP;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_eq_n   <= 1'b1;
      r_gt_n   <= 1'b1;
      r_lt_n   <= 1'b1;
      r_dec_gt <= 1'b0;
      r_dec_lt <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_q      <= w_q;
      r_p      <= w_p;
      r_idx    <= w_idx;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_eq_n   <= w_eq_n;
      r_gt_n   <= w_gt_n;
      r_lt_n   <= w_lt_n;
      r_dec_gt <= w_dec_gt_nx;
      r_dec_lt <= w_dec_lt_nx;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign p_eq_q_n = r_eq_n;
  assign p_gt_q_n = r_gt_n;
  assign p_lt_q_n = r_lt_n;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Bench for seq_mag_comparator: an unsigned and a signed instance share all
// inputs; results and latency are checked against an arithmetic model.
module tb_seq_mag_comparator;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;
  localparam int MAXLAT = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             q_load = 1'b0;
  logic [WIDTH-1:0] q_in = '0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] p_in = '0;

  logic busy_u, done_u, eq_u, gt_u, lt_u;
  logic busy_s, done_s, eq_s, gt_s, lt_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_mag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT), .SIGNED(0)) u_dut (
    .clk(clk), .rst(rst), .q_load(q_load), .q_in(q_in), .start(start), .p_in(p_in),
    .busy(busy_u), .done(done_u), .p_eq_q_n(eq_u), .p_gt_q_n(gt_u), .p_lt_q_n(lt_u));

  seq_mag_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .q_load(q_load), .q_in(q_in), .start(start), .p_in(p_in),
    .busy(busy_s), .done(done_s), .p_eq_q_n(eq_s), .p_gt_q_n(gt_s), .p_lt_q_n(lt_s));

  // Expected {eq_n, gt_n, lt_n} from plain integer comparison
  function automatic logic [2:0] exp_res(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] q,
                                         input bit is_signed);
    int pi, qi;
    if (is_signed) begin
      pi = int'($signed(p));
      qi = int'($signed(q));
    end else begin
      pi = int'({16'd0, p});
      qi = int'({16'd0, q});
    end
    if (pi == qi)     return 3'b011;
    else if (pi > qi) return 3'b101;
    else              return 3'b110;
  endfunction

  // Expected number of examine edges: NDIG, or 1 + leading equal digits with early exit
  function automatic int exp_lat(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] q);
    logic [WIDTH-1:0] x;
    int msb;
    x = p ^ q;
    msb = -1;
    for (int b = 0; b < WIDTH; b++) if (x[b]) msb = b;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    if (msb < 0) return NDIG;
    return ((WIDTH - 1 - msb) / DIGIT) + 1;
`else
    return NDIG;
`endif
  endfunction

  // Drive one comparison starting in IDLE; returns latency and both results
  task automatic do_cmp(input logic [WIDTH-1:0] p, input bit ld, input logic [WIDTH-1:0] qv,
                        input bit noise, output int lat, output logic [2:0] ru,
                        output logic [2:0] rs, output logic busy_seen);
    start = 1'b1; p_in = p; q_load = ld; q_in = qv;
    @(posedge clk); #1;
    start = 1'b0; q_load = 1'b0;
    busy_seen = busy_u & busy_s;
    lat = 0;
    while (1) begin
      if (noise) begin
        start = 1'b1; q_load = 1'b1; q_in = '0; p_in = WIDTH'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (done_u || lat >= MAXLAT) break;
    end
    start = 1'b0; q_load = 1'b0;
    ru = {eq_u, gt_u, lt_u};
    rs = {eq_s, gt_s, lt_s};
  endtask

  task automatic load_q(input logic [WIDTH-1:0] qv);
    q_load = 1'b1; q_in = qv;
    @(posedge clk); #1;
    q_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if ({busy_u, done_u, eq_u, gt_u, lt_u} !== 5'b00111) begin
      n_err++; $display("FAIL reset_u: got %b expected 00111", {busy_u, done_u, eq_u, gt_u, lt_u});
    end
    n_cmp++;
    if ({busy_s, done_s, eq_s, gt_s, lt_s} !== 5'b00111) begin
      n_err++; $display("FAIL reset_s: got %b expected 00111", {busy_s, done_s, eq_s, gt_s, lt_s});
    end
  endtask

  // Single directed comparison with result, latency and busy checks
  task automatic test_directed(input string name, input logic [WIDTH-1:0] q,
                               input logic [WIDTH-1:0] p);
    int lat; logic [2:0] ru, rs; logic bs;
    load_q(q);
    do_cmp(p, 1'b0, '0, 1'b0, lat, ru, rs, bs);
    n_cmp++;
    if (ru !== exp_res(p, q, 0) || rs !== exp_res(p, q, 1)) begin
      n_err++; $display("FAIL %s_result: got u=%b s=%b expected u=%b s=%b", name, ru, rs,
                        exp_res(p, q, 0), exp_res(p, q, 1));
    end
    n_cmp++;
    if (lat !== exp_lat(p, q) || bs !== 1'b1 || done_s !== 1'b1) begin
      n_err++; $display("FAIL %s_timing: got lat=%0d busy=%b done_s=%b expected lat=%0d busy=1 done_s=1",
                        name, lat, bs, done_s, exp_lat(p, q));
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done_u !== 1'b0 || ru !== {eq_u, gt_u, lt_u}) begin
      n_err++; $display("FAIL %s_pulse_hold: got done=%b res=%b expected done=0 res=%b",
                        name, done_u, {eq_u, gt_u, lt_u}, ru);
    end
  endtask

  task automatic test_same_cycle();
    int lat; logic [2:0] ru, rs; logic bs;
    do_cmp(16'h00FF, 1'b1, 16'h00FF, 1'b1, lat, ru, rs, bs);
    n_cmp++;
    if (ru !== 3'b011 || lat !== NDIG) begin
      n_err++; $display("FAIL same_cycle: got res=%b lat=%0d expected res=011 lat=%0d", ru, lat, NDIG);
    end
    do_cmp(16'h00FF, 1'b0, '0, 1'b0, lat, ru, rs, bs);
    n_cmp++;
    if (ru !== 3'b011) begin
      n_err++; $display("FAIL busy_ignored_eq: got %b expected 011", ru);
    end
    do_cmp(16'h0100, 1'b0, '0, 1'b0, lat, ru, rs, bs);
    n_cmp++;
    if (ru !== 3'b101 || lat !== exp_lat(16'h0100, 16'h00FF)) begin
      n_err++; $display("FAIL busy_ignored_gt: got res=%b lat=%0d expected res=101 lat=%0d",
                        ru, lat, exp_lat(16'h0100, 16'h00FF));
    end
  endtask

  // Start reissued in the done cycle; each result and period checked
  task automatic test_back_to_back();
    int lat1, lat2; logic [2:0] ru, rs; logic bs;
    logic [WIDTH-1:0] q, p1, p2;
    time t0, t1;
    q = WIDTH'($urandom); p1 = q ^ 16'h0040; p2 = WIDTH'($urandom);
    load_q(q);
    t0 = $time;
    do_cmp(p1, 1'b0, '0, 1'b0, lat1, ru, rs, bs);
    n_cmp++;
    if (ru !== exp_res(p1, q, 0) || rs !== exp_res(p1, q, 1)) begin
      n_err++; $display("FAIL b2b_first: got u=%b s=%b expected u=%b s=%b", ru, rs,
                        exp_res(p1, q, 0), exp_res(p1, q, 1));
    end
    do_cmp(p2, 1'b0, '0, 1'b0, lat2, ru, rs, bs);
    t1 = $time;
    n_cmp++;
    if (ru !== exp_res(p2, q, 0) || rs !== exp_res(p2, q, 1) ||
        (t1 - t0) != 64'(10 * (exp_lat(p1, q) + 1 + exp_lat(p2, q) + 1))) begin
      n_err++; $display("FAIL b2b_second: got u=%b s=%b span=%0t expected u=%b s=%b span=%0d", ru, rs,
                        t1 - t0, exp_res(p2, q, 0), exp_res(p2, q, 1),
                        10 * (exp_lat(p1, q) + 1 + exp_lat(p2, q) + 1));
    end
  endtask

  task automatic test_random();
    int lat; logic [2:0] ru, rs; logic bs;
    logic [WIDTH-1:0] q, p, m;
    int errs;
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      q = WIDTH'($urandom);
      m = WIDTH'(16'hFFFF >> (DIGIT * $urandom_range(0, NDIG)));
      p = (q & ~m) | (WIDTH'($urandom) & m);
      do_cmp(p, 1'b1, q, 1'b0, lat, ru, rs, bs);
      if (ru !== exp_res(p, q, 0) || rs !== exp_res(p, q, 1) || lat != exp_lat(p, q)) begin
        errs++;
        $display("FAIL random_%0d: p=%h q=%h got u=%b s=%b lat=%0d expected u=%b s=%b lat=%0d",
                 i, p, q, ru, rs, lat, exp_res(p, q, 0), exp_res(p, q, 1), exp_lat(p, q));
      end
    end
    n_cmp++;
    if (errs !== 0) begin
      n_err++; $display("FAIL random_summary: got %0d bad expected 0", errs);
    end
  endtask

  task automatic test_midrun_reset();
    int seen;
    load_q(16'h0002);
    start = 1'b1; p_in = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({busy_u, done_u, eq_u, gt_u, lt_u} !== 5'b00111 ||
        {busy_s, done_s, eq_s, gt_s, lt_s} !== 5'b00111) begin
      n_err++; $display("FAIL midrun_reset: got u=%b s=%b expected 00111",
                        {busy_u, done_u, eq_u, gt_u, lt_u}, {busy_s, done_s, eq_s, gt_s, lt_s});
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done_u || done_s || busy_u) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++; $display("FAIL midrun_no_done: got %0d active cycles expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed("equal", 16'h1234, 16'h1234);
    test_directed("gt_top", 16'h1234, 16'h9234);
    test_directed("signed_neg1", 16'hFFFF, 16'h0000);
    test_directed("low_digit", 16'h5678, 16'h5677);
    test_same_cycle();
    test_back_to_back();
    test_random();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
